// File: rtl/mesh_noc_pkg.sv
// mesh_noc_pkg: shared defaults, VC encoding and requester indices for the mesh router.
package mesh_noc_pkg;
   localparam int PACKET_WIDTH_DEF = 64;
   localparam int NUM_REQ_DEF = 4;
   localparam int VC_BIT = PACKET_WIDTH_DEF - 1;
   localparam int CW = 0;
   localparam int CCW = 1;
   localparam int VERT = 2;
   localparam int PE = 3;
   typedef enum logic {VC_EVEN = 1'b0, VC_ODD = 1'b1} vc_e;
endpackage

// File: rtl/output_port_arbiter_if.sv
// output_port_arbiter_if: requester side and downstream side of one router output port.
interface output_port_arbiter_if import mesh_noc_pkg::*; #(
   parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
   parameter int NUM_REQ = NUM_REQ_DEF
);
   logic polarity;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ*PACKET_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0] grant;
   logic ro;
   logic so;
   logic [PACKET_WIDTH-1:0] do_data;
   modport slave (input polarity, req, req_data, ro, output grant, so, do_data);
   modport master (output polarity, req, req_data, ro, input grant, so, do_data);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first eligible index at or after ptr.
module rr_arbiter import mesh_noc_pkg::*; #(
   parameter int N = NUM_REQ_DEF,
   parameter int PW = N > 1 ? $clog2(N) : 1
) (
   input  logic [N-1:0]  elig,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx
);
   // scan from the farthest offset down so the closest eligible index wins
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (elig[PW'((int'(ptr) + k) % N)]) begin
            idx = PW'((int'(ptr) + k) % N);
            gnt = N'(1) << idx;
         end
      end
   end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: fills the internal-VC buffer from a round-robin winner
// while the external-VC buffer drains downstream; polarity swaps the roles.
module output_port_arbiter import mesh_noc_pkg::*; #(
   parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input logic clk,
   input logic reset,
   output_port_arbiter_if.slave bus
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   vc_e ivc, evc;
   logic [PACKET_WIDTH-1:0] pkt [NUM_REQ];
   logic [NUM_REQ-1:0] elig, arb_gnt;
   logic [PW-1:0] win;
   logic [PACKET_WIDTH-1:0] buf_q [2], buf_d [2];
   logic [1:0] full_q, full_d;
   logic [PW-1:0] rr_ptr_q [2], rr_ptr_d [2];
   logic so;
   assign ivc = vc_e'(bus.polarity);
   assign evc = vc_e'(~bus.polarity);
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign pkt[i] = bus.req_data[i*PACKET_WIDTH +: PACKET_WIDTH];
      assign elig[i] = bus.req[i] & (pkt[i][PACKET_WIDTH-1] == bus.polarity) & ~full_q[ivc];
   end
   rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
      .elig(elig),
      .ptr(rr_ptr_q[ivc]),
      .gnt(arb_gnt),
      .idx(win)
   );
   // outputs are gated by reset so nothing escapes while the flags are held clear
   assign so = ~reset & full_q[evc] & bus.ro;
   assign bus.so = so;
   assign bus.grant = reset ? '0 : arb_gnt;
   assign bus.do_data = so ? buf_q[evc] : '0;
   always_comb begin
      buf_d = buf_q;
      full_d = full_q;
      rr_ptr_d = rr_ptr_q;
      if (|arb_gnt) begin
         buf_d[ivc] = pkt[win];
         full_d[ivc] = 1'b1;
         rr_ptr_d[ivc] = win == PW'(NUM_REQ - 1) ? '0 : win + PW'(1);
      end
      if (so) full_d[evc] = 1'b0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_q <= '{default: '0};
         full_q <= '0;
         rr_ptr_q <= '{default: '0};
      end else begin
         buf_q <= buf_d;
         full_q <= full_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed scenarios with literal expectations plus a
// random phase checked every cycle against a buffer/queue model of the port.
module tb_output_port_arbiter;
   import mesh_noc_pkg::*;
   localparam int W = 64;
   localparam int N = 4;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   output_port_arbiter_if #(.PACKET_WIDTH(W), .NUM_REQ(N)) bus ();
   output_port_arbiter #(.PACKET_WIDTH(W), .NUM_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));
   int n_chk = 0;
   int n_fail = 0;
   logic [1:0] mfull;
   logic [W-1:0] mbuf [2];
   int mptr [2];
   logic [W-1:0] sbq0 [$];
   logic [W-1:0] sbq1 [$];
   logic [3:0] exp_g [5];
   int exp_i [5];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: one slot per VC, lowest round-robin distance from the VC's pointer wins
   function automatic void model(output logic [N-1:0] g, output int w, output logic s, output logic [W-1:0] d);
      int iv;
      iv = int'(bus.polarity);
      g = '0;
      w = -1;
      if (!mfull[iv])
         for (int k = 0; k < N; k++) begin
            int i;
            i = (mptr[iv] + k) % N;
            if (w < 0 && bus.req[i] && bus.req_data[i*W+W-1] == bus.polarity) begin
               w = i;
               g[i] = 1'b1;
            end
         end
      s = mfull[1-iv] && bus.ro;
      d = s ? mbuf[1-iv] : '0;
   endfunction

   always @(posedge clk or posedge reset) begin
      logic [N-1:0] g;
      int w;
      logic s;
      logic [W-1:0] d;
      int iv;
      if (reset) begin
         mfull = '0;
         mptr[0] = 0;
         mptr[1] = 0;
         sbq0.delete();
         sbq1.delete();
      end else begin
         model(g, w, s, d);
         iv = int'(bus.polarity);
         if (w >= 0) begin
            mbuf[iv] = bus.req_data[w*W +: W];
            mfull[iv] = 1'b1;
            mptr[iv] = (w + 1) % N;
            if (iv == 0) sbq0.push_back(mbuf[iv]);
            else sbq1.push_back(mbuf[iv]);
         end
         if (s) begin
            mfull[1-iv] = 1'b0;
            if (iv == 1 && sbq0.size() > 0) void'(sbq0.pop_front());
            if (iv == 0 && sbq1.size() > 0) void'(sbq1.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] g;
      int w;
      logic s;
      logic [W-1:0] d;
      logic [W-1:0] front;
      if (!reset) begin
         model(g, w, s, d);
         chk("grant", W'(bus.grant), W'(g));
         chk("so", W'(bus.so), W'(s));
         chk("do_data", bus.do_data, d);
         chk("grant_onehot", W'($countones(bus.grant) <= 1), W'(1));
         if (s) begin
            front = 'x;
            if (bus.polarity && sbq0.size() > 0) front = sbq0[0];
            if (!bus.polarity && sbq1.size() > 0) front = sbq1[0];
            chk("sb_order", bus.do_data, front);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pkt(input int i, input logic [W-1:0] v);
      bus.req_data[i*W +: W] = v;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic [W-1:0] v;
      reset = 1'b1;
      bus.polarity = 1'b0;
      bus.req = '1;
      bus.req_data = '0;
      bus.ro = 1'b1;
      #2;
      chk("rst_grant", W'(bus.grant), '0);
      chk("rst_so", W'(bus.so), '0);
      chk("rst_do_data", bus.do_data, '0);
      step();
      step();
      reset = 1'b0;
      // single even packet, drained on the following odd cycle
      bus.req = 4'b0001;
      bus.ro = 1'b0;
      set_pkt(CW, 64'h0000_0000_0000_00A5);
      #1;
      chk("t1_grant", W'(bus.grant), W'(4'b0001));
      step();
      bus.polarity = 1'b1;
      bus.ro = 1'b1;
      bus.req = '0;
      #1;
      chk("t1_so", W'(bus.so), W'(1));
      chk("t1_do_data", bus.do_data, 64'h0000_0000_0000_00A5);
      chk("t1_grant_idle", W'(bus.grant), '0);
      step();
      // rotation over four even requesters
      do_reset();
      for (int i = 0; i < N; i++) set_pkt(i, 64'h100 + 64'(i));
      bus.req = 4'b1111;
      bus.ro = 1'b1;
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_i = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
         bus.polarity = 1'b0;
         #1;
         chk("t2_grant", W'(bus.grant), W'(exp_g[k]));
         step();
         bus.polarity = 1'b1;
         #1;
         chk("t2_so", W'(bus.so), W'(1));
         chk("t2_do_data", bus.do_data, 64'h100 + 64'(exp_i[k]));
         step();
      end
      // odd packet only granted on an odd cycle
      do_reset();
      bus.polarity = 1'b0;
      bus.req = 4'b0100;
      bus.ro = 1'b0;
      set_pkt(VERT, 64'h8000_0000_0000_0022);
      #1;
      chk("t3_grant_even", W'(bus.grant), '0);
      step();
      bus.polarity = 1'b1;
      #1;
      chk("t3_grant_odd", W'(bus.grant), W'(4'b0100));
      step();
      bus.polarity = 1'b0;
      bus.ro = 1'b1;
      bus.req = '0;
      #1;
      chk("t3_so", W'(bus.so), W'(1));
      chk("t3_do_data", bus.do_data, 64'h8000_0000_0000_0022);
      step();
      // backpressure holds the even buffer and blocks even grants
      do_reset();
      bus.polarity = 1'b0;
      bus.req = 4'b0001;
      bus.ro = 1'b0;
      set_pkt(CW, 64'h35);
      #1;
      chk("t4_grant_first", W'(bus.grant), W'(4'b0001));
      step();
      for (int k = 0; k < 6; k++) begin
         bus.polarity = (k % 2 == 0);
         #1;
         chk("t4_so_held", W'(bus.so), '0);
         chk("t4_grant_blocked", W'(bus.grant), '0);
         step();
      end
      bus.polarity = 1'b1;
      bus.ro = 1'b1;
      #1;
      chk("t4_so", W'(bus.so), W'(1));
      chk("t4_do_data", bus.do_data, 64'h35);
      step();
      bus.polarity = 1'b0;
      #1;
      chk("t4_grant_resume", W'(bus.grant), W'(4'b0001));
      step();
      // asynchronous reset with both buffers full
      do_reset();
      bus.polarity = 1'b0;
      bus.req = 4'b0001;
      bus.ro = 1'b0;
      set_pkt(CW, 64'h50);
      #1;
      chk("t5_fill_even", W'(bus.grant), W'(4'b0001));
      step();
      bus.polarity = 1'b1;
      set_pkt(CW, 64'h8000_0000_0000_0051);
      #1;
      chk("t5_fill_odd", W'(bus.grant), W'(4'b0001));
      step();
      bus.polarity = 1'b0;
      bus.ro = 1'b1;
      #1;
      chk("t5_so_before", W'(bus.so), W'(1));
      chk("t5_do_data_before", bus.do_data, 64'h8000_0000_0000_0051);
      #1;
      reset = 1'b1;
      bus.req = 4'b1111;
      for (int i = 0; i < N; i++) set_pkt(i, 64'h60 + 64'(i));
      #1;
      chk("t5_async_so", W'(bus.so), '0);
      chk("t5_async_grant", W'(bus.grant), '0);
      chk("t5_async_do_data", bus.do_data, '0);
      #2;
      reset = 1'b0;
      #1;
      chk("t5_first_grant", W'(bus.grant), W'(4'b0001));
      step();
      // random traffic, checked by the per-cycle compare process
      for (int c = 0; c < 10000; c++) begin
         bus.req = 4'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) begin
            v = {$urandom, $urandom};
            v[W-1] = 1'($urandom_range(0, 1));
            set_pkt(i, v);
         end
         bus.ro = ($urandom_range(0, 3) != 0);
         bus.polarity = 1'($urandom_range(0, 1));
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter PACKET_WIDTH, default 64, packet width in bits; bit PACKET_WIDTH-1 is the VC bit (0 even, 1 odd).
REQ-002 Parameter NUM_REQ, default 4, number of requesters: 0 cw, 1 ccw, 2 vertical, 3 PE.
REQ-003 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Port polarity, input, 1, router polarity; internal VC ivc = polarity, external VC evc = ~polarity.
REQ-006 Port req, input, NUM_REQ, per-requester send request (si).
REQ-007 Port req_data, input, NUM_REQ*PACKET_WIDTH, requester i packet at slice [i*PACKET_WIDTH +: PACKET_WIDTH].
REQ-008 Port grant, output, NUM_REQ, one-hot acceptance; the packet is captured at the same edge.
REQ-009 Port ro, input, 1, downstream ready for the evc channel.
REQ-010 Port so, output, 1, send strobe to downstream.
REQ-011 Port do_data, output, PACKET_WIDTH, packet to downstream, valid while so=1.

Function
REQ-012 Storage: two one-entry buffers, buf[0] even and buf[1] odd, each with a full flag.
REQ-013 Eligible(i) = req[i] & (req_data_i[PACKET_WIDTH-1] == ivc) & ~full[ivc].
REQ-014 grant is combinational, at most one bit high, and zero when no requester is eligible.
REQ-015 Winner = first eligible index scanning rr_ptr[ivc], rr_ptr[ivc]+1, ... modulo NUM_REQ.
REQ-016 On a grant to winner w at the edge: buf[ivc] takes req_data_w, full[ivc] goes to 1, and rr_ptr[ivc] goes to (w+1) mod NUM_REQ.
REQ-017 With no grant, rr_ptr[ivc] holds; rr_ptr[evc] never changes in a cycle.
REQ-018 Requesters whose VC bit is not ivc are ignored that cycle and are not granted.
REQ-019 so = full[evc] & ro; do_data = buf[evc] when so=1, otherwise all zeros.
REQ-020 When so=1 at an edge, full[evc] clears; data in buf[evc] need not be cleared.
REQ-021 Fill and drain in the same cycle always target different buffers (ivc != evc), so no collision case exists.
REQ-022 A full buffer blocks all grants for its VC until it drains on a later external cycle, giving a minimum two-cycle turnaround per VC.
REQ-023 Latency: a packet granted at edge N is presented on so/do_data no earlier than cycle N+1, and only when polarity has flipped to make its VC external and ro=1.
REQ-024 ro low: full[evc] holds, and so and do_data stay 0.
REQ-025 polarity is sampled combinationally each cycle; a non-toggling polarity is legal and drains nothing for the held ivc.

Reset
REQ-026 reset asserted clears full[1:0] and sets rr_ptr[0] = rr_ptr[1] = 0 immediately, without waiting for clk.
REQ-027 During reset grant = 0, so = 0 and do_data = 0, regardless of req or ro.
REQ-028 Reset mid-transfer discards buffered packets; the first edge after deassertion behaves as after power-on.

Structure
REQ-029 Package mesh_noc_pkg holds the PACKET_WIDTH default, the NUM_REQ default, the VC bit index, and the requester index constants CW, CCW, VERT, PE.
REQ-030 Sub-module rr_arbiter holds one combinational round-robin picker (eligible vector plus pointer in, one-hot grant out); it is instantiated once and fed by the ivc-selected pointer.
REQ-031 State is limited to the two buffers, the two full flags and the two rr pointers.

Verification
REQ-032 Reset then polarity=0, req=4'b0001 with even packet 0x0000_0000_0000_00A5 -> grant=0001 that cycle; next cycle with polarity=1, ro=1 -> so=1 and do_data=0x...A5.
REQ-033 polarity=0, req=4'b1111, all packets even, ro=1, polarity toggling -> successive even grants are 0001, 0010, 0100, 1000, 0001.
REQ-034 polarity=0, req[2]=1 with packet MSB=1 (odd) -> grant=0000; with polarity=1 -> grant=0100.
REQ-035 buf[0] full, ro=0 for 6 cycles -> so=0 throughout and no even grants; ro=1 on an odd-polarity cycle -> so=1, and the even grant resumes on the next even cycle.
REQ-036 Assert reset while both buffers are full, asynchronously between edges -> so and grant go to 0 immediately; after release the first grant goes to requester 0 when req=4'b1111.
REQ-037 Random req, VC bits and ro for 10k cycles with a scoreboard -> every granted packet appears exactly once on do_data, in order per VC, and grant is never multi-hot.
